// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: each rising edge of valid queues char, frames go out LSB first at CLK_HZ/BAUD.
// Idle push reaches the line as a start bit two cycles later; a push into a full FIFO with no pop is dropped and flags overflow.
module uart_tx_buffer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [7:0]            char,
  input  logic                  valid,
  output logic                  uart_tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int BW    = $clog2(DIV);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [BW-1:0]       BAUD_LAST = BW'(DIV - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e                state_q, state_d;
  logic                  v1_q, v2_q, v3_q;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic [7:0]            mem_q [DEPTH];

  logic                  push, push_ok, pop, empty, full, baud_end;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            head;

  always_comb begin
    push     = v2_q & ~v3_q;
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    baud_end = (baud_q == BAUD_LAST);
    head     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Reload straight from the stop bit so consecutive frames have no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase

    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    push_ok    = push & (~full | pop);
    overflow_d = overflow_q | (push & full & ~pop);
    wr_ptr_d   = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
    rd_ptr_d   = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      v1_q       <= valid;
      v2_q       <= v1_q;
      v3_q       <= v2_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= char;
  end

  assign uart_tx    = tx_q;
  assign busy       = (state_q != S_IDLE) | ~empty;
  assign fifo_count = count;
  assign overflow   = overflow_q;

endmodule
